// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch: instruction-fetch stage of the MIPS CPU.
//
// Owns the program counter. It drives the word address of an asynchronous
// instruction ROM and registers the returned instruction, together with its
// byte PC, into a single output slot. Decode drains the slot through a
// valid/ready handshake. Branch/jump redirects from decode/execute reload the
// PC and squash the slot. Accepted handshakes are counted for the debug display.
//
// Optional feature (macro IF_ADDR_ERR_EN): a redirect to a target that is not
// word-aligned traps. The stage then enters a sticky ERR state that only rst
// leaves. Without the macro, the low target bits are kept in the PC but do not
// take part in addressing, and if_addr_err is tied low.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word-aligned)
//   ADDR_W       ROM word-address width; rom_addr = pc[ADDR_W+1:2]
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   rom_addr     word address to the instruction ROM (combinational from pc)
//   rom_inst     ROM read data for rom_addr, same cycle
//   if_valid     output slot holds an instruction
//   if_pc        byte PC of the slot instruction
//   if_inst      slot instruction
//   id_ready     decode accepts the slot this cycle
//   br_valid     redirect request (single-cycle pulse)
//   br_target    redirect byte address
//   fetch_cnt    accepted handshakes since reset (wraps)
//   if_addr_err  misaligned redirect trapped (IF_ADDR_ERR_EN only)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    input  logic              id_ready,
    input  logic              br_valid,
    input  logic [31:0]       br_target,
    output logic [31:0]       fetch_cnt,
    output logic              if_addr_err
);

    typedef enum logic {RUN, ERR} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] slot_pc_q;
    logic [31:0] slot_inst_q;
    logic [31:0] cnt_q;

    logic [31:0] pc_d;
    logic [31:0] cnt_d;
    logic        xfer;
    logic        load;

    // A transfer needs an occupied slot; id_ready alone means nothing.
    assign xfer  = valid_q && id_ready;
    // The slot may be refilled when it is empty or is being drained this cycle.
    assign load  = !valid_q || id_ready;
    assign pc_d  = pc_q + 32'd4;
    assign cnt_d = cnt_q + 32'd1;

    // Only the word bits of the PC register address the ROM; the
    // returned data never feeds back into the address.
    assign rom_addr = pc_q[ADDR_W+1:2];

`ifdef IF_ADDR_ERR_EN
    logic err_q;
    assign if_addr_err = err_q;
`else
    assign if_addr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            slot_pc_q   <= 32'h0;
            slot_inst_q <= 32'h0;
            cnt_q       <= 32'h0;
`ifdef IF_ADDR_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // A transfer in a redirect cycle still counts.
            if (xfer) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                RUN: begin
                    if (br_valid) begin
                        // Redirect wins over load; the slot is squashed
                        // (no delay slot) and the target is fetched next.
                        pc_q    <= br_target;
                        valid_q <= 1'b0;
`ifdef IF_ADDR_ERR_EN
                        if (br_target[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
`endif
                    end else if (load) begin
                        valid_q     <= 1'b1;
                        slot_pc_q   <= pc_q;
                        slot_inst_q <= rom_inst;
                        pc_q        <= pc_d;
                    end
                end
                default: begin
                    // Trapped: no fetch, PC kept for debug.
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid  = valid_q;
    assign if_pc     = slot_pc_q;
    assign if_inst   = slot_inst_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] fetch_cnt;
    logic        if_addr_err;

    // Second instance starting near the top of the ROM to exercise address wrap.
    logic [4:0]  w_rom_addr;
    logic [31:0] w_rom_inst;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_inst;
    logic [31:0] w_fetch_cnt;
    logic        w_if_addr_err;

    logic [31:0] rom [32];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the stage.
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;
    logic        m_err;

    assign rom_inst   = rom[rom_addr];
    assign w_rom_inst = rom[w_rom_addr];

    inst_fetch #(.RESET_PC(32'h0), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .br_valid(br_valid), .br_target(br_target),
        .fetch_cnt(fetch_cnt), .if_addr_err(if_addr_err)
    );

    inst_fetch #(.RESET_PC(32'h7C), .ADDR_W(5)) u_wrap (
        .clk(clk), .rst(rst), .rom_addr(w_rom_addr), .rom_inst(w_rom_inst),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst),
        .id_ready(1'b1), .br_valid(1'b0), .br_target(32'h0),
        .fetch_cnt(w_fetch_cnt), .if_addr_err(w_if_addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the stage's rules,
    // then compare the DUT against the model just after the edge.
    task automatic cycle(input logic r, input logic br, input logic [31:0] tgt, input logic rdy);
        logic [31:0] fetched;
        rst = r; br_valid = br; br_target = tgt; id_ready = rdy;
        check("rom_addr", {27'd0, rom_addr}, {27'd0, m_pc[6:2]});
        fetched = rom[m_pc[6:2]];
        if (r) begin
            m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
            m_cnt = 32'h0; m_err = 1'b0;
        end else begin
            if (m_v && rdy) m_cnt = m_cnt + 1;
            if (m_err) begin
                m_v = 1'b0;
            end else if (br) begin
                m_pc = tgt;
                m_v  = 1'b0;
`ifdef IF_ADDR_ERR_EN
                if (tgt[1:0] != 2'b00) m_err = 1'b1;
`endif
            end else if (!m_v || rdy) begin
                m_v = 1'b1; m_ipc = m_pc; m_inst = fetched; m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
        check("if_valid", {31'd0, if_valid}, {31'd0, m_v});
        check("fetch_cnt", fetch_cnt, m_cnt);
        check("if_addr_err", {31'd0, if_addr_err}, {31'd0, m_err});
        if (m_v) begin
            check("if_pc", if_pc, m_ipc);
            check("if_inst", if_inst, m_inst);
        end
    endtask

    initial begin
        logic        r, br, rdy;
        logic [31:0] tgt;

        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0] = 32'h2401_0001;
        rom[1] = 32'h0001_1100;
        rst = 1'b1; br_valid = 1'b0; br_target = 32'h0; id_ready = 1'b0;
        m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
        m_cnt = 32'h0; m_err = 1'b0;
        @(posedge clk); #1;

        // Reset state
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("wrap_rst_addr", {27'd0, w_rom_addr}, 32'd31);

        // Stream from reset PC
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("s0_pc", if_pc, 32'h0);
        check("s0_inst", if_inst, 32'h2401_0001);
        check("wrap_pc0", w_if_pc, 32'h7C);
        check("wrap_inst0", w_if_inst, rom[31]);
        check("wrap_addr0", {27'd0, w_rom_addr}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("s1_pc", if_pc, 32'h4);
        check("s1_inst", if_inst, 32'h0001_1100);
        check("wrap_pc1", w_if_pc, 32'h80);
        check("wrap_inst1", w_if_inst, rom[0]);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("s2_pc", if_pc, 32'h8);
        check("s2_cnt", fetch_cnt, 32'd2);

        // Stall while slot holds 0x8
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check("stall_pc", if_pc, 32'h8);
            check("stall_cnt", fetch_cnt, 32'd2);
            check("stall_addr", {27'd0, rom_addr}, 32'd3);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("release_pc", if_pc, 32'hC);

        // Walk to 0x30, then redirect to 0x34 while stalled
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("at30_pc", if_pc, 32'h30);
        cycle(1'b0, 1'b1, 32'h34, 1'b0);
        check("redir_empty", {31'd0, if_valid}, 32'd0);
        check("redir_cnt", fetch_cnt, 32'd12);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_pc", if_pc, 32'h34);
        check("redir_inst", if_inst, rom[13]);
        check("redir_cnt2", fetch_cnt, 32'd12);

        // Back-to-back redirects: last one wins
        cycle(1'b0, 1'b1, 32'h10, 1'b1);
        cycle(1'b0, 1'b1, 32'h20, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("b2b_pc", if_pc, 32'h20);

        // Reset during a redirect
        cycle(1'b1, 1'b1, 32'h40, 1'b1);
        check("mrst_cnt", fetch_cnt, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_pc", if_pc, 32'h0);

        // Wrap through redirect to the last ROM word
        cycle(1'b0, 1'b1, 32'h7C, 1'b1);
        check("wrap_addr31", {27'd0, rom_addr}, 32'd31);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr_next", {27'd0, rom_addr}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc80", if_pc, 32'h80);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            br  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) tgt = $urandom;
            else tgt = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) tgt = tgt | 32'hFFFF_FF00;
            cycle(r, br, tgt, rdy);
        end

        // Misaligned redirect
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h36, 1'b1);
`ifdef IF_ADDR_ERR_EN
        check("mis_err", {31'd0, if_addr_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check("mis_hold_valid", {31'd0, if_valid}, 32'd0);
            check("mis_hold_err", {31'd0, if_addr_err}, 32'd1);
        end
`else
        check("mis_noerr", {31'd0, if_addr_err}, 32'd0);
        check("mis_addr13", {27'd0, rom_addr}, 32'd13);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_pc36", if_pc, 32'h36);
        check("mis_inst13", if_inst, rom[13]);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_pc3a", if_pc, 32'h3A);
        check("mis_inst14", if_inst, rom[14]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
